// File: rtl/arith_logic_unit_seq.sv
// arith_logic_unit_seq: multi-cycle add/sub/mul/div/logic engine with valid/ready handshakes.
// Optional ALU_OP_CNT_EN adds op_count, a wrapping count of completed result handshakes.
module arith_logic_unit_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
`ifdef ALU_OP_CNT_EN
    ,output logic [15:0]       op_count
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, result_q, result_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d, dbz_q, dbz_d;
    logic [WIDTH:0]     trial, rem_n;
    logic               ge, iter, div0;
    logic [2*WIDTH-1:0] mul_step, div_step, ext_a, ext_b, single;
    logic [WIDTH-1:0]   logic_res;
`ifdef ALU_OP_CNT_EN
    logic [15:0]        op_count_q, op_count_d;
`endif

    always_comb begin
        ext_a     = {{WIDTH{1'b0}}, a_q};
        ext_b     = {{WIDTH{1'b0}}, b_q};
        // div keeps the partial remainder in the upper half and shifts quotient bits into the lower half
        trial     = {acc_q[2*WIDTH-1:WIDTH], a_q[cnt_q]};
        ge        = trial >= {1'b0, b_q};
        rem_n     = ge ? trial - {1'b0, b_q} : trial;
        div_step  = {rem_n[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
        mul_step  = {acc_q[2*WIDTH-2:0], 1'b0} + (b_q[cnt_q] ? ext_a : '0);
        div0      = !mode_q && op_q == 2'd3 && b_q == '0;
        iter      = !mode_q && op_q[1] && !div0;
        logic_res = op_q == 2'd0 ? ~(a_q & b_q) :
                    op_q == 2'd1 ? ~(a_q | b_q) :
                    op_q == 2'd2 ? ~a_q : a_q ^ b_q;
        single    = mode_q        ? {{WIDTH{1'b0}}, logic_res} :
                    op_q == 2'd0  ? ext_a + ext_b :
                    op_q == 2'd1  ? ext_a - ext_b :
                    {a_q, {WIDTH{1'b1}}};
        state_d  = state_q;
        mode_d   = mode_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                mode_d  = mode;
                op_d    = op;
                a_d     = data1;
                b_d     = data2;
                acc_d   = '0;
                cnt_d   = CW'(WIDTH - 1);
                state_d = CALC;
            end
            CALC: begin
                dbz_d = div0;
                if (iter) begin
                    acc_d = op_q[0] ? div_step : mul_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        result_d = acc_d;
                        state_d  = DONE;
                    end
                end else begin
                    result_d = single;
                    state_d  = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = state_d == IDLE;
        out_valid_d = state_d == DONE;
`ifdef ALU_OP_CNT_EN
        op_count_d = op_count_q + ((out_valid_q && out_ready) ? 16'd1 : 16'd0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ALU_OP_CNT_EN
            op_count_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_OP_CNT_EN
            op_count_q  <= op_count_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;
`ifdef ALU_OP_CNT_EN
    assign op_count    = op_count_q;
`endif

endmodule

// File: tb/tb_arith_logic_unit_seq.sv
// tb_arith_logic_unit_seq: directed and random commands checked against an arithmetic reference model.
module tb_arith_logic_unit_seq;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst, in_valid, in_ready, mode, out_valid, out_ready, div_by_zero;
    logic [1:0]     op;
    logic [W-1:0]   data1, data2;
    logic [2*W-1:0] result;
`ifdef ALU_OP_CNT_EN
    logic [15:0]    op_count;
`endif
    int n_vec = 0, n_err = 0, hs_cnt = 0;

    always #5 clk = ~clk;

    arith_logic_unit_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .op(op), .data1(data1), .data2(data2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .div_by_zero(div_by_zero)
`ifdef ALU_OP_CNT_EN
        , .op_count(op_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic m, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        logic z;
        z = 1'b0;
        if (!m) begin
            case (o)
                2'd0: r = 16'(a) + 16'(b);
                2'd1: r = 16'(a) - 16'(b);
                2'd2: r = 16'(a) * 16'(b);
                default: if (b == 0) begin
                    r = {a, 8'hFF};
                    z = 1'b1;
                end else r = {a % b, a / b};
            endcase
        end else begin
            case (o)
                2'd0: r = {8'h00, ~(a & b)};
                2'd1: r = {8'h00, ~(a | b)};
                2'd2: r = {8'h00, ~a};
                default: r = {8'h00, a ^ b};
            endcase
        end
        return {z, r};
    endfunction

    function automatic int lat_of(input logic m, input logic [1:0] o, input logic [7:0] b);
        return (!m && (o == 2'd2 || (o == 2'd3 && b != 0))) ? W + 1 : 2;
    endfunction

    task automatic run(input logic m, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [16:0] e;
        int lat;
        e = model(m, o, a, b);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; mode = m; op = o; data1 = a; data2 = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = (hold == 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("in_ready_busy", in_ready, 0);
            if (!out_valid) begin
                data1 = W'($urandom); data2 = W'($urandom); mode = 1'($urandom); op = 2'($urandom);
            end
        end while (!out_valid && lat < 40);
        chk("latency", lat, lat_of(m, o, b));
        chk("result", result, e[15:0]);
        chk("div_by_zero", div_by_zero, e[16]);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("hold_result", result, e[15:0]);
            chk("hold_dbz", div_by_zero, e[16]);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        hs_cnt++;
        @(negedge clk);
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; op = '0; data1 = '0; data2 = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_dbz", div_by_zero, 0);
`ifdef ALU_OP_CNT_EN
        chk("rst_op_count", op_count, 0);
`endif
        run(0, 0, 200, 100, 0);
        run(0, 1, 3, 5, 0);
        run(0, 2, 255, 255, 0);
        run(0, 3, 200, 7, 0);
        run(0, 3, 13, 0, 0);
        run(1, 0, 8'hF0, 8'h3C, 0);
        run(1, 1, 8'hF0, 8'h3C, 0);
        run(1, 2, 8'hA5, 8'hFF, 0);
        run(1, 3, 8'hF0, 8'h3C, 5);
        run(0, 2, 8'hB7, 8'h6D, 5);
        // a command offered together with rst must not be taken
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; mode = 1'b0; op = 2'd0; data1 = 8'd1; data2 = 8'd2;
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid_ignored", out_valid, 0);
        chk("rst_valid_in_ready", in_ready, 1);
        run(0, 0, 8'h11, 8'h22, 0);
        // reset in the 4th CALC cycle of a mul discards it
        @(negedge clk);
        in_valid = 1'b1; mode = 1'b0; op = 2'd2; data1 = 8'd255; data2 = 8'd255;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        hs_cnt = 0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_result", result, 0);
        chk("midrst_dbz", div_by_zero, 0);
`ifdef ALU_OP_CNT_EN
        chk("midrst_op_count", op_count, 0);
`endif
        repeat (3) @(negedge clk);
        chk("midrst_stays_idle", out_valid, 0);
        run(0, 0, 8'h01, 8'h01, 0);
        run(0, 3, 8'hFF, 8'h10, 1);
        run(1, 3, 8'h55, 8'hAA, 0);
`ifdef ALU_OP_CNT_EN
        chk("op_count_3", op_count, 3);
`endif
        for (int k = 0; k < 60; k++) begin
            logic [7:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run(1'($urandom), 2'($urandom), 8'($urandom), rb, int'($urandom_range(0, 3)));
        end
`ifdef ALU_OP_CNT_EN
        chk("op_count_end", op_count, 32'(hs_cnt));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
